// File: rtl/fft_frame_seq.sv
// Frame scheduler for the 512-point FFT path: ping-pong input capture, core load/start/unload.
// Build option: define FFT_SEQ_STATS_EN to implement the frame_count/drop_count registers.
module fft_frame_seq #(
  parameter int N_LOG2 = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [N_LOG2-1:0] wr_addr,
  output logic              rd_bank,
  output logic [N_LOG2-1:0] rd_addr,
  output logic              core_load,
  output logic [N_LOG2-1:0] core_load_addr,
  output logic              core_start,
  input  logic              core_done,
  output logic [N_LOG2-1:0] core_rd_addr,
  input  logic              out_busy,
  output logic              out_wr_en,
  output logic [N_LOG2-1:0] out_wr_addr,
  output logic              frame_done,
  output logic              overrun,
  output logic [15:0]       frame_count,
  output logic [15:0]       drop_count
);

  localparam logic [N_LOG2-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    PROC,
    WAIT_OUT,
    UNLOAD,
    RELEASE
  } state_t;

  state_t     state;
  logic [1:0] bank_full;
  logic       proc_bank;
  logic       stall;
  logic       rd_valid;
  logic       cr_valid;
  logic       release_now;
  logic       other_free;
  logic       wr_last;

  // A release in this cycle frees the other bank for the capture side immediately,
  // so a bank completing in the same cycle never counts as an overrun.
  assign release_now = (state == RELEASE);
  assign other_free  = !bank_full[!wr_bank] || (release_now && (proc_bank == !wr_bank));
  assign wr_en       = sample_valid && !stall;
  assign wr_last     = wr_en && (wr_addr == LAST_ADDR);

  // ---------------------------------------------------------------------------
  // Capture side
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank <= 1'b0;
      wr_addr <= '0;
      stall   <= 1'b0;
      overrun <= 1'b0;
    end else if (stall) begin
      if (sample_valid) begin
        overrun <= 1'b1;
      end
      if (other_free) begin
        stall   <= 1'b0;
        wr_bank <= !wr_bank;
        wr_addr <= '0;
      end
    end else if (wr_en) begin
      if (wr_addr == LAST_ADDR) begin
        if (other_free) begin
          wr_bank <= !wr_bank;
          wr_addr <= '0;
        end else begin
          stall <= 1'b1;
        end
      end else begin
        wr_addr <= wr_addr + 1'b1;
      end
    end
  end

  // The filling bank and the bank being released are always distinct.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_full <= 2'b00;
    end else begin
      if (wr_last && !wr_bank) begin
        bank_full[0] <= 1'b1;
      end else if (release_now && !proc_bank) begin
        bank_full[0] <= 1'b0;
      end
      if (wr_last && wr_bank) begin
        bank_full[1] <= 1'b1;
      end else if (release_now && proc_bank) begin
        bank_full[1] <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      proc_bank      <= 1'b0;
      rd_bank        <= 1'b0;
      rd_addr        <= '0;
      rd_valid       <= 1'b0;
      core_load      <= 1'b0;
      core_load_addr <= '0;
      core_start     <= 1'b0;
      core_rd_addr   <= '0;
      cr_valid       <= 1'b0;
      out_wr_en      <= 1'b0;
      out_wr_addr    <= '0;
      frame_done     <= 1'b0;
    end else begin
      core_start <= 1'b0;
      frame_done <= 1'b0;
      core_load  <= 1'b0;
      out_wr_en  <= 1'b0;
      case (state)
        IDLE: begin
          if (bank_full[proc_bank]) begin
            state    <= LOAD;
            rd_bank  <= proc_bank;
            rd_addr  <= '0;
            rd_valid <= 1'b1;
          end
        end
        LOAD: begin
          // Input RAM read data arrives one cycle after the address.
          core_load      <= rd_valid;
          core_load_addr <= rd_addr;
          if (rd_valid) begin
            if (rd_addr == LAST_ADDR) begin
              rd_valid <= 1'b0;
            end else begin
              rd_addr <= rd_addr + 1'b1;
            end
          end else begin
            state      <= START;
            core_start <= 1'b1;
          end
        end
        START: begin
          state <= PROC;
        end
        PROC: begin
          if (core_done) begin
            state <= WAIT_OUT;
          end
        end
        WAIT_OUT: begin
          if (!out_busy) begin
            state        <= UNLOAD;
            core_rd_addr <= '0;
            cr_valid     <= 1'b1;
          end
        end
        UNLOAD: begin
          out_wr_en   <= cr_valid;
          out_wr_addr <= core_rd_addr;
          if (cr_valid) begin
            if (core_rd_addr == LAST_ADDR) begin
              cr_valid <= 1'b0;
            end else begin
              core_rd_addr <= core_rd_addr + 1'b1;
            end
          end else begin
            state      <= RELEASE;
            frame_done <= 1'b1;
          end
        end
        RELEASE: begin
          proc_bank <= !proc_bank;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef FFT_SEQ_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      if (release_now) begin
        frame_count <= frame_count + 16'd1;
      end
      if (stall && sample_valid) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end
`else
  assign frame_count = '0;
  assign drop_count  = '0;
`endif

endmodule

// File: tb/tb_fft_frame_seq.sv
// Directed bench for fft_frame_seq: load/unload address scoreboards plus cycle-exact checks
// of capture, overrun, out_busy hold, coincident release and mid-unload reset.
`timescale 1ns/1ps
module tb_fft_frame_seq;

  localparam int N_LOG2 = 9;
  localparam int N      = 512;
`ifdef FFT_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              sample_valid = 1'b0;
  logic              core_done = 1'b0;
  logic              out_busy = 1'b0;
  logic              wr_en;
  logic              wr_bank;
  logic [N_LOG2-1:0] wr_addr;
  logic              rd_bank;
  logic [N_LOG2-1:0] rd_addr;
  logic              core_load;
  logic [N_LOG2-1:0] core_load_addr;
  logic              core_start;
  logic [N_LOG2-1:0] core_rd_addr;
  logic              out_wr_en;
  logic [N_LOG2-1:0] out_wr_addr;
  logic              frame_done;
  logic              overrun;
  logic [15:0]       frame_count;
  logic [15:0]       drop_count;

  int checks = 0;
  int errors = 0;
  int load_q[$];
  int out_q[$];

  fft_frame_seq #(.N_LOG2(N_LOG2)) dut (
    .clk            (clk),
    .reset          (reset),
    .sample_valid   (sample_valid),
    .wr_en          (wr_en),
    .wr_bank        (wr_bank),
    .wr_addr        (wr_addr),
    .rd_bank        (rd_bank),
    .rd_addr        (rd_addr),
    .core_load      (core_load),
    .core_load_addr (core_load_addr),
    .core_start     (core_start),
    .core_done      (core_done),
    .core_rd_addr   (core_rd_addr),
    .out_busy       (out_busy),
    .out_wr_en      (out_wr_en),
    .out_wr_addr    (out_wr_addr),
    .frame_done     (frame_done),
    .overrun        (overrun),
    .frame_count    (frame_count),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboards: every core_load / out_wr_en must match the next queued address.
  always @(negedge clk) begin
    if (!reset) begin
      if (core_load) begin
        check("core_load_addr", 32'(core_load_addr), (load_q.size() > 0) ? load_q.pop_front() : -1);
      end
      if (out_wr_en) begin
        check("out_wr_addr", 32'(out_wr_addr), (out_q.size() > 0) ? out_q.pop_front() : -1);
      end
    end
  end

  task automatic push_load();
    for (int i = 0; i < N; i++) load_q.push_back(i);
  endtask

  task automatic push_out();
    for (int i = 0; i < N; i++) out_q.push_back(i);
  endtask

  // Advance one cycle, drive inputs just after the edge, then let combinational outputs settle.
  task automatic cyc(input logic sv, input logic cd);
    @(posedge clk);
    #1;
    sample_valid = sv;
    core_done    = cd;
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  task automatic feed(input int n, input logic bank, input bit accept);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0);
      check("wr_en", 32'(wr_en), 32'(accept));
      if (accept) begin
        check("wr_addr", 32'(wr_addr), i);
        check("wr_bank", 32'(wr_bank), 32'(bank));
      end
    end
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    core_done    = 1'b0;
    out_busy     = 1'b0;
    reset        = 1'b1;
    load_q.delete();
    out_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_bank", 32'(wr_bank), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_rd_bank", 32'(rd_bank), 0);
    check("rst_rd_addr", 32'(rd_addr), 0);
    check("rst_core_load", 32'(core_load), 0);
    check("rst_core_load_addr", 32'(core_load_addr), 0);
    check("rst_core_start", 32'(core_start), 0);
    check("rst_core_rd_addr", 32'(core_rd_addr), 0);
    check("rst_out_wr_en", 32'(out_wr_en), 0);
    check("rst_out_wr_addr", 32'(out_wr_addr), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_frame_count", 32'(frame_count), 0);
    check("rst_drop_count", 32'(drop_count), 0);
  endtask

  // Entered in the cycle holding a bank's last sample with the FSM idle and no further
  // samples; returns in the core_start cycle.
  task automatic load_phase(input logic bank);
    wait_cycles(1);
    check("wr_bank_toggle", 32'(wr_bank), 32'(!bank));
    check("wr_addr_wrap", 32'(wr_addr), 0);
    check("core_load_early", 32'(core_load), 0);
    wait_cycles(1);
    check("rd_bank", 32'(rd_bank), 32'(bank));
    check("rd_addr_first", 32'(rd_addr), 0);
    check("core_load_latency", 32'(core_load), 0);
    wait_cycles(1);
    check("core_load_first", 32'(core_load), 1);
    wait_cycles(N - 1);
    check("core_start_early", 32'(core_start), 0);
    wait_cycles(1);
    check("core_start", 32'(core_start), 1);
    check("load_contiguous", load_q.size(), 0);
  endtask

  // Entered in the core_done cycle with out_busy low; returns in the last write cycle.
  task automatic unload_phase();
    wait_cycles(2);
    check("out_wr_latency", 32'(out_wr_en), 0);
    check("core_rd_addr_first", 32'(core_rd_addr), 0);
    wait_cycles(1);
    check("out_wr_first", 32'(out_wr_en), 1);
    wait_cycles(N - 1);
    check("out_wr_last", 32'(out_wr_en), 1);
    check("frame_done_early", 32'(frame_done), 0);
  endtask

  initial begin
    bit saw_wr;

    // Reset and first frame on bank 0, core_done 100 cycles after core_start.
    do_reset();
    check_reset_values();
    push_load();
    push_out();
    feed(N, 1'b0, 1'b1);
    load_phase(1'b0);
    wait_cycles(99);
    cyc(1'b0, 1'b1);
    unload_phase();
    wait_cycles(1);
    check("frame_done_pulse", 32'(frame_done), 1);
    check("unload_contiguous", out_q.size(), 0);
    wait_cycles(1);
    check("frame_done_single", 32'(frame_done), 0);
    check("frame_count_1", 32'(frame_count), STATS ? 32'd1 : 32'd0);
    check("bank0_released", 32'(dut.bank_full[0]), 0);

    // Second frame on bank 1 with out_busy held for 2000 cycles after core_done.
    out_busy = 1'b1;
    push_load();
    push_out();
    feed(N, 1'b1, 1'b1);
    load_phase(1'b1);
    wait_cycles(9);
    cyc(1'b0, 1'b1);
    saw_wr = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      wait_cycles(1);
      if (out_wr_en) saw_wr = 1'b1;
    end
    check("wait_out_hold", 32'(saw_wr), 0);
    wait_cycles(1);
    out_busy = 1'b0;
    wait_cycles(1);
    check("busy_fall_latency", 32'(out_wr_en), 0);
    wait_cycles(1);
    check("busy_fall_first_wr", 32'(out_wr_en), 1);
    wait_cycles(N - 1);
    check("busy_frame_done_early", 32'(frame_done), 0);
    wait_cycles(1);
    check("busy_frame_done", 32'(frame_done), 1);
    wait_cycles(1);
    check("frame_count_2", 32'(frame_count), STATS ? 32'd2 : 32'd0);

    // 1536 samples with core_done held low: bank 1 fills, then 512 drops.
    push_load();
    feed(N, 1'b0, 1'b1);
    feed(N, 1'b1, 1'b1);
    feed(N, 1'b1, 1'b0);
    check("stall_overrun", 32'(overrun), 1);
    check("stall_drop_count", 32'(drop_count), STATS ? 32'd512 : 32'd0);
    check("stall_wr_bank", 32'(wr_bank), 1);
    check("stall_load_done", load_q.size(), 0);
    push_out();
    cyc(1'b0, 1'b1);
    unload_phase();
    cyc(1'b1, 1'b0);
    check("stall_release_pulse", 32'(frame_done), 1);
    check("stall_release_drop", 32'(wr_en), 0);
    push_load();
    cyc(1'b1, 1'b0);
    check("resume_wr_en", 32'(wr_en), 1);
    check("resume_wr_addr", 32'(wr_addr), 0);
    check("resume_wr_bank", 32'(wr_bank), 0);
    check("resume_drop_count", 32'(drop_count), STATS ? 32'd513 : 32'd0);
    check("resume_overrun_sticky", 32'(overrun), 1);
    check("frame_count_3", 32'(frame_count), STATS ? 32'd3 : 32'd0);

    // Bank 1 completes in the same cycle RELEASE frees bank 0.
    do_reset();
    check("reset_clears_overrun", 32'(overrun), 0);
    check("reset_clears_drops", 32'(drop_count), 0);
    push_load();
    feed(N, 1'b0, 1'b1);
    feed(N - 1, 1'b1, 1'b1);
    wait_cycles(4);
    check("coinc_core_start", 32'(core_start), 1);
    check("coinc_load_done", load_q.size(), 0);
    push_out();
    wait_cycles(4);
    cyc(1'b0, 1'b1);
    unload_phase();
    cyc(1'b1, 1'b0);
    check("coinc_release", 32'(frame_done), 1);
    check("coinc_wr_en", 32'(wr_en), 1);
    check("coinc_wr_addr", 32'(wr_addr), 511);
    check("coinc_wr_bank", 32'(wr_bank), 1);
    push_load();
    cyc(1'b0, 1'b0);
    check("coinc_toggle_bank", 32'(wr_bank), 0);
    check("coinc_toggle_addr", 32'(wr_addr), 0);
    check("coinc_no_overrun", 32'(overrun), 0);
    check("coinc_no_drop", 32'(drop_count), 0);

    // Bank 1 frame starts straight after the release; reset it at unload address 200.
    wait_cycles(513);
    check("b1_core_start_early", 32'(core_start), 0);
    wait_cycles(1);
    check("b1_core_start", 32'(core_start), 1);
    check("b1_rd_bank", 32'(rd_bank), 1);
    push_out();
    wait_cycles(2);
    cyc(1'b0, 1'b1);
    wait_cycles(203);
    check("mid_unload_wr", 32'(out_wr_en), 1);
    check("mid_unload_addr", 32'(out_wr_addr), 200);
    do_reset();
    check_reset_values();

    // Clean frame on bank 0 after the abandoned one.
    push_load();
    push_out();
    feed(N, 1'b0, 1'b1);
    load_phase(1'b0);
    wait_cycles(9);
    cyc(1'b0, 1'b1);
    unload_phase();
    wait_cycles(1);
    check("clean_frame_done", 32'(frame_done), 1);
    check("clean_unload_drained", out_q.size(), 0);
    wait_cycles(1);
    check("clean_frame_count", 32'(frame_count), STATS ? 32'd1 : 32'd0);
    check("clean_overrun", 32'(overrun), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_seq.md
# fft_frame_seq

Frame-level scheduler for the 512-point FFT path. Manages a two-bank (ping-pong) input sample RAM so I2S capture continues while the FFT core processes the previous frame. Sequences core load, start, completion wait and result unload into the SPI output buffer. Runs entirely on the single system clock, with no derived slow clocks.

## Interface
- N_LOG2, 9, log2 of frame length N (N = 512)
- reset  in  1  asynchronous, active-high
- clk  in  1  system clock (48 MHz)
- sample_valid  in  1  one-cycle pulse per new I2S sample
- wr_en  out  1  write strobe to input RAM; equals sample_valid when a bank is accepting
- wr_bank  out  1  input RAM bank being written
- wr_addr  out  N_LOG2  input RAM write address
- rd_bank  out  1  input RAM bank being read into the core
- rd_addr  out  N_LOG2  input RAM read address; RAM has 1-cycle registered read
- core_load  out  1  core load strobe
- core_load_addr  out  N_LOG2  core load address
- core_start  out  1  one-cycle start pulse
- core_done  in  1  level or pulse from core when transform complete
- core_rd_addr  out  N_LOG2  core result read address; 1-cycle read latency
- out_busy  in  1  output buffer still being drained by SPI
- out_wr_en  out  1  output buffer write strobe
- out_wr_addr  out  N_LOG2  output buffer write address
- frame_done  out  1  one-cycle pulse when a frame is fully unloaded
- overrun  out  1  sticky: a sample was dropped since reset
- frame_count  out  16  frames completed (see Configuration)
- drop_count  out  16  samples dropped (see Configuration)

## Operation
- Capture side:
  - bank_full[1:0] flags start at 0. wr_bank starts at 0 and wr_addr at 0.
  - On sample_valid with the current bank accepting: wr_en=1 and wr_addr increments.
  - At wr_addr = N-1 the bank is marked full.
  - If the other bank is free, wr_bank toggles and wr_addr returns to 0.
  - Otherwise capture enters STALL. In STALL, every sample_valid is dropped (wr_en=0), overrun is set and drop_count increments.
  - STALL exits when the other bank is released. wr_bank then toggles and wr_addr=0.
- Frame FSM states: IDLE, LOAD, START, PROC, WAIT_OUT, UNLOAD, RELEASE.
  - IDLE -> LOAD when bank_full[proc_bank]. proc_bank starts at 0 and toggles in RELEASE.
  - LOAD: rd_bank=proc_bank and rd_addr steps 0..N-1, one per cycle. core_load and core_load_addr are rd-side valid/addr delayed exactly 1 cycle. Goes to START after address N-1 has been issued and the trailing load cycle has completed.
  - START: core_start=1 for one cycle, then PROC.
  - PROC -> WAIT_OUT on core_done.
  - WAIT_OUT -> UNLOAD when out_busy=0.
  - UNLOAD: core_rd_addr steps 0..N-1. out_wr_en and out_wr_addr are core_rd_addr-valid delayed 1 cycle. Goes to RELEASE after the last write.
  - RELEASE (1 cycle): clears bank_full[proc_bank], toggles proc_bank, pulses frame_done, increments frame_count, then IDLE.
- Simultaneous events: a release in cycle t and bank completion in the same cycle t is not an overrun, because the release is seen combinationally by the capture side. A sample arriving in the release cycle while in STALL is dropped; capture resumes the next cycle.
- Reset mid-operation: all FSMs go to IDLE, flags and counters clear, and any in-flight core or output transaction is abandoned.

## Timing
- Reset values: all strobes 0, all addresses 0, wr_bank=rd_bank=0, overrun=0, counts=0.
- From bank full to first core_load: 2 cycles (IDLE->LOAD, then the RAM latency cycle).
- Load: N+1 cycles. START: 1 cycle.
- From core_done to first out_wr_en: 2 cycles if out_busy=0.
- Unload: N+1 cycles. RELEASE: 1 cycle.
- Fixed overhead excluding core compute and out_busy wait: 2N+5 cycles (1029 for N=512). This is well under one sample period × N, so no overrun occurs at steady state unless the core or out_busy stalls.
- Counters wrap modulo 2^16.
- overrun clears only on reset.

## Configuration
- FFT_SEQ_STATS_EN:
  - Defined: frame_count and drop_count registers are implemented as specified.
  - Undefined: both outputs are tied to 0 and no counter flops are synthesized. The overrun flag is always present.

## Test plan
- Reset, then 512 sample_valid pulses -> wr_addr 0..511 on bank 0, then wr_bank=1. rd_bank=0 LOAD begins 2 cycles later. core_load_addr runs 0..511 contiguously.
- Full frame with core_done 100 cycles after core_start and out_busy=0 -> 512 out_wr_en with addr 0..511, then one frame_done pulse. frame_count=1 and bank_full[0]=0.
- Hold out_busy=1 for 2000 cycles after core_done -> FSM stays in WAIT_OUT with no out_wr_en. Unload starts 2 cycles after out_busy falls.
- Hold core_done low while feeding 1536 samples -> bank 1 fills, then STALL. 512 drops give drop_count=512 and overrun=1. Once frame 0 releases, capture resumes on bank 0 at addr 0.
- Bank 1 fills in the same cycle that RELEASE frees bank 0 -> no drop, overrun stays 0, and wr_bank=0 next cycle.
- Assert reset during UNLOAD at addr 200 -> all outputs return to reset values. The next 512 samples produce a clean frame on bank 0.
